// File: rtl/serv_state_wide.sv
// serv_state_wide: serial instruction sequencer; one 32-bit pass takes 32/W beats of W bits each.
// Build option SERV_STATE_MDU_EN adds multiply/divide two-stage sequencing (i_mdu_op, i_mdu_ready).
module serv_state_wide #(
    parameter int W     = 1,
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_new_irq,
    input  logic             i_rf_ready,
    input  logic             i_take_branch,
    input  logic             i_branch_op,
    input  logic             i_mem_op,
    input  logic             i_shift_op,
    input  logic             i_slt_op,
    input  logic             i_mem_cmd,
    input  logic             i_e_op,
    input  logic             i_ebreak,
    input  logic [4:0]       i_rs1_addr,
    input  logic             i_ctrl_misalign,
    input  logic             i_mem_misalign,
    input  logic             i_alu_sh_done,
`ifdef SERV_STATE_MDU_EN
    input  logic             i_mdu_op,
    input  logic             i_mdu_ready,
`endif
    output logic             o_init,
    output logic             o_run,
    output logic             o_ctrl_trap,
    output logic             o_cnt_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cnt_done,
    output logic             o_ctrl_pc_en,
    output logic             o_ctrl_jump,
    output logic             o_rf_rs_en,
    output logic             o_alu_shamt_en,
    output logic             o_dbus_cyc,
    output logic [1:0]       o_mem_bytecnt,
    output logic [3:0]       o_csr_mcause,
    output logic             o_bufreg_hold,
    output logic [W-1:0]     o_csr_imm
);

    if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
        $error("serv_state_wide: W must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_TRAP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cnt_done;
    logic             r_ctrl_jump;
    logic             r_bufreg_hold;
    logic [3:0]       r_mcause;
    logic             r_pending_irq;
    logic             r_stage_two_pending;

    logic             w_two_stage;
    logic             w_mem_misalign;
    logic             w_init_trap;
    logic             w_hold_op;
    logic             w_resume;
    logic [5:0]       w_idx;
    logic [W-1:0]     w_csr_imm;

`ifdef SERV_STATE_MDU_EN
    assign w_two_stage = i_slt_op | i_mem_op | i_branch_op | i_shift_op | i_mdu_op;
    assign w_hold_op   = i_mem_op | i_shift_op | i_mdu_op;
    assign w_resume    = r_stage_two_pending &
                         ((i_shift_op & i_alu_sh_done) | (i_mdu_op & i_mdu_ready));
`else
    assign w_two_stage = i_slt_op | i_mem_op | i_branch_op | i_shift_op;
    assign w_hold_op   = i_mem_op | i_shift_op;
    assign w_resume    = r_stage_two_pending & i_shift_op & i_alu_sh_done;
`endif

    assign w_mem_misalign = i_mem_op & i_mem_misalign;
    assign w_init_trap    = w_mem_misalign | (i_take_branch & i_ctrl_misalign);

    assign o_init         = (r_state == S_INIT);
    assign o_run          = (r_state == S_RUN);
    assign o_ctrl_trap    = (r_state == S_TRAP);
    assign o_cnt_en       = (r_state != S_IDLE);
    assign o_cnt          = r_cnt;
    assign o_cnt_done     = r_cnt_done;
    assign o_ctrl_pc_en   = o_run | o_ctrl_trap;
    assign o_ctrl_jump    = r_ctrl_jump;
    assign o_rf_rs_en     = w_two_stage ? o_init : o_ctrl_pc_en;
    assign o_alu_shamt_en = o_init & (r_cnt < CNT_W'(5));
    assign o_dbus_cyc     = (r_state == S_IDLE) & r_stage_two_pending & i_mem_op & ~w_mem_misalign;
    assign o_mem_bytecnt  = r_cnt[4:3];
    assign o_csr_mcause   = r_mcause;
    assign o_bufreg_hold  = r_bufreg_hold;
    assign o_csr_imm      = w_csr_imm;

    // Only rs1 bits 0..4 exist; beats above bit 4 read as zero.
    always_comb begin
        w_csr_imm = '0;
        w_idx     = '0;
        for (int k = 0; k < W; k++) begin
            w_idx = {1'b0, r_cnt} + 6'(k);
            if (w_idx < 6'd5) begin
                w_csr_imm[k] = i_rs1_addr[w_idx[2:0]];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state             <= S_IDLE;
            r_cnt               <= '0;
            r_cnt_done          <= 1'b0;
            r_ctrl_jump         <= 1'b0;
            r_bufreg_hold       <= 1'b0;
            r_mcause            <= 4'd0;
            r_pending_irq       <= 1'b0;
            r_stage_two_pending <= 1'b0;
        end else begin
            if (i_e_op) begin
                r_mcause <= {~i_ebreak, 3'b011};
            end else if (w_mem_misalign) begin
                r_mcause <= {2'b01, i_mem_cmd, 1'b0};
            end else begin
                r_mcause <= 4'd0;
            end

            if (i_new_irq) begin
                r_pending_irq <= 1'b1;
            end else if (r_state == S_TRAP) begin
                r_pending_irq <= 1'b0;
            end

            if (o_cnt_en) begin
                r_cnt               <= r_cnt + CNT_W'(W);
                r_stage_two_pending <= o_init;
            end

            // A pass never leaves early, so the beat before last predicts cnt_done.
            r_cnt_done    <= o_cnt_en && (r_cnt == CNT_W'(32 - 2 * W));
            r_bufreg_hold <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_ctrl_jump <= 1'b0;
                    if (i_rf_ready) begin
                        if (i_e_op | r_pending_irq) begin
                            r_state <= S_TRAP;
                        end else if (w_two_stage & ~r_stage_two_pending) begin
                            r_state <= S_INIT;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else if (w_resume) begin
                        r_state <= S_RUN;
                    end
                end
                S_INIT: begin
                    r_ctrl_jump <= i_take_branch;
                    if (r_cnt_done) begin
                        if (w_init_trap) begin
                            r_state <= S_TRAP;
                        end else if (w_hold_op) begin
                            r_state       <= S_IDLE;
                            r_bufreg_hold <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                default: begin
                    if (r_cnt_done) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
